uc_pilha: RTL

UC_PILHA -- requirements
Module: uc_pilha

---
 rtl/pilha_pkg.sv | 38 +++
 rtl/uc_decode.sv | 47 ++++
 rtl/uc_pilha.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pilha_pkg.sv
// rtl/pilha_pkg.sv - opcodes, error codes and FSM states shared by the stack control unit and the ULA
package pilha_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_PUSH  = 5'b00001;
   localparam logic [4:0] OP_POP   = 5'b00010;
   localparam logic [4:0] OP_ADD   = 5'b00011;
   localparam logic [4:0] OP_SUB   = 5'b00100;
   localparam logic [4:0] OP_MUL   = 5'b00101;
   localparam logic [4:0] OP_DIV   = 5'b00110;
   localparam logic [4:0] OP_AND   = 5'b00111;
   localparam logic [4:0] OP_NAND  = 5'b01000;
   localparam logic [4:0] OP_OR    = 5'b01001;
   localparam logic [4:0] OP_XOR   = 5'b01010;
   localparam logic [4:0] OP_CMP   = 5'b01011;
   localparam logic [4:0] OP_NOT   = 5'b01100;
   localparam logic [4:0] OP_IF_EQ = 5'b01101;
   localparam logic [4:0] OP_IF_GT = 5'b01110;
   localparam logic [4:0] OP_IF_LT = 5'b01111;
   localparam logic [4:0] OP_IF_GE = 5'b10000;
   localparam logic [4:0] OP_IF_LE = 5'b10001;

   localparam logic [1:0] EC_NONE  = 2'b00;
   localparam logic [1:0] EC_OVF   = 2'b01;
   localparam logic [1:0] EC_UNF   = 2'b10;
   localparam logic [1:0] EC_ILL   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH,
      ST_POP,
      ST_LD1,
      ST_LD2,
      ST_EXEC,
      ST_DONE
   } state_t;

endpackage

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - combinational opcode classifier for the stack control unit
module uc_decode
   import pilha_pkg::*;
(
   input  logic [4:0] i_op,
   output logic       o_legal,
   output logic [1:0] o_n_ops,
   output logic       o_push_result,
   output logic       o_is_cmp
);

   // o_n_ops is the stack occupancy the instruction consumes before it may start
   always_comb begin
      o_legal       = 1'b0;
      o_n_ops       = 2'd0;
      o_push_result = 1'b0;
      o_is_cmp      = 1'b0;
      case (i_op)
         OP_NOP, OP_PUSH: begin
            o_legal = 1'b1;
         end
         OP_POP: begin
            o_legal = 1'b1;
            o_n_ops = 2'd1;
         end
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
         OP_NAND, OP_OR, OP_XOR, OP_CMP: begin
            o_legal       = 1'b1;
            o_n_ops       = 2'd2;
            o_push_result = 1'b1;
         end
         OP_NOT: begin
            o_legal       = 1'b1;
            o_n_ops       = 2'd1;
            o_push_result = 1'b1;
         end
         OP_IF_EQ, OP_IF_GT, OP_IF_LT, OP_IF_GE, OP_IF_LE: begin
            o_legal  = 1'b1;
            o_n_ops  = 2'd2;
            o_is_cmp = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/uc_pilha.sv
// rtl/uc_pilha.sv - stack machine control unit: sequences push/pop/ALU/compare over the datapath stack
module uc_pilha
   import pilha_pkg::*;
#(
   parameter int DEPTH = 16
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       instr_valid,
   output logic                       instr_ready,
   input  logic [4:0]                 instr_op,
   input  logic [15:0]                instr_imm,
   input  logic                       cond_in,
   output logic                       wren,
   output logic                       pilha_en,
   output logic                       controle_pilha,
   output logic                       load_temp1,
   output logic                       load_temp2,
   output logic [15:0]                din_UC,
   output logic [4:0]                 opcode,
   output logic                       done,
   output logic                       err,
   output logic [1:0]                 err_code,
   output logic                       flag,
   output logic [$clog2(DEPTH+1)-1:0] sp
);

   localparam int SPW = $clog2(DEPTH+1);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic           w_legal;
   logic [1:0]     w_n_ops;
   logic           w_push_result;
   logic           w_is_cmp;
   logic           w_accept;
   state_t         w_state_nxt;
   logic [1:0]     w_ec_nxt;

   state_t         r_state;
   logic [SPW-1:0] r_sp;
   logic           r_flag;
   logic [4:0]     r_opcode;
   logic [15:0]    r_din;
   logic           r_push_res;
   logic           r_is_cmp;
   logic           r_two;
   logic           r_pilha_en;
   logic           r_wren;
   logic           r_ctrl;
   logic           r_lt1;
   logic           r_lt2;
   logic           r_done;
   logic           r_err;
   logic [1:0]     r_err_code;

   uc_decode u_decode (
      .i_op          (instr_op),
      .o_legal       (w_legal),
      .o_n_ops       (w_n_ops),
      .o_push_result (w_push_result),
      .o_is_cmp      (w_is_cmp)
   );

   assign w_accept = (r_state == ST_IDLE) && instr_valid;

   // Rejected instructions skip straight to DONE so no stack strobe is ever issued for them
   always_comb begin
      w_state_nxt = r_state;
      w_ec_nxt    = EC_NONE;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) begin
               if (!w_legal) begin
                  w_state_nxt = ST_DONE;
                  w_ec_nxt    = EC_ILL;
               end else if (instr_op == OP_PUSH) begin
                  if (r_sp == SP_FULL) begin
                     w_state_nxt = ST_DONE;
                     w_ec_nxt    = EC_OVF;
                  end else begin
                     w_state_nxt = ST_PUSH;
                  end
               end else if (r_sp < SPW'(w_n_ops)) begin
                  w_state_nxt = ST_DONE;
                  w_ec_nxt    = EC_UNF;
               end else if (instr_op == OP_NOP) begin
                  w_state_nxt = ST_DONE;
               end else if (instr_op == OP_POP) begin
                  w_state_nxt = ST_POP;
               end else begin
                  w_state_nxt = ST_LD1;
               end
            end
         end
         ST_PUSH, ST_POP, ST_EXEC: w_state_nxt = ST_DONE;
         ST_LD1:  w_state_nxt = r_two ? ST_LD2 : ST_EXEC;
         ST_LD2:  w_state_nxt = ST_EXEC;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with r_state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_sp       <= '0;
         r_flag     <= 1'b0;
         r_opcode   <= OP_NOP;
         r_din      <= '0;
         r_push_res <= 1'b0;
         r_is_cmp   <= 1'b0;
         r_two      <= 1'b0;
         r_pilha_en <= 1'b0;
         r_wren     <= 1'b0;
         r_ctrl     <= 1'b0;
         r_lt1      <= 1'b0;
         r_lt2      <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= EC_NONE;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_opcode   <= instr_op;
            r_din      <= instr_imm;
            r_push_res <= w_push_result;
            r_is_cmp   <= w_is_cmp;
            r_two      <= (w_n_ops == 2'd2);
         end
         case (r_state)
            ST_PUSH:                r_sp <= r_sp + SP_ONE;
            ST_POP, ST_LD1, ST_LD2: r_sp <= r_sp - SP_ONE;
            ST_EXEC: if (r_push_res) r_sp <= r_sp + SP_ONE;
            default: begin
            end
         endcase
         if (r_state == ST_EXEC && r_is_cmp) begin
            r_flag <= cond_in;
         end
         r_pilha_en <= (w_state_nxt == ST_PUSH) || (w_state_nxt == ST_POP) ||
                       (w_state_nxt == ST_LD1)  || (w_state_nxt == ST_LD2)  ||
                       (w_state_nxt == ST_EXEC && r_push_res);
         r_wren     <= (w_state_nxt == ST_PUSH) || (w_state_nxt == ST_EXEC && r_push_res);
         r_ctrl     <= (w_state_nxt == ST_EXEC) && r_push_res;
         r_lt1      <= (w_state_nxt == ST_LD1);
         r_lt2      <= (w_state_nxt == ST_LD2);
         r_done     <= (w_state_nxt == ST_DONE);
         r_err      <= (w_ec_nxt != EC_NONE);
         r_err_code <= w_ec_nxt;
      end
   end

   assign instr_ready    = (r_state == ST_IDLE);
   assign wren           = r_wren;
   assign pilha_en       = r_pilha_en;
   assign controle_pilha = r_ctrl;
   assign load_temp1     = r_lt1;
   assign load_temp2     = r_lt2;
   assign din_UC         = r_din;
   assign opcode         = r_opcode;
   assign done           = r_done;
   assign err            = r_err;
   assign err_code       = r_err_code;
   assign flag           = r_flag;
   assign sp             = r_sp;

endmodule
